// File: rtl/apb_mon_pkg.sv
// Shared definitions for the APB protocol monitor.
// Contents: bus phase enum, error bit indices, helper to pick the
// lowest-index error out of an error vector.
package apb_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } phase_e;

    localparam int unsigned ERR_NO_SETUP  = 0;
    localparam int unsigned ERR_NO_ACCESS = 1;
    localparam int unsigned ERR_UNSTABLE  = 2;
    localparam int unsigned ERR_TIMEOUT   = 3;
    localparam int unsigned ERR_WR_ADDR   = 4;
    localparam int unsigned ERR_ABORT     = 5;
    localparam int unsigned NUM_ERR       = 6;

    function automatic logic [2:0] lowest_err(input logic [NUM_ERR-1:0] e);
        logic found;
        lowest_err = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_ERR; i++) begin
            if (e[i] && !found) begin
                lowest_err = 3'(i);
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating counter with clear and parallel load.
// Ports: i_clk, i_rst_n (async, active-low), i_inc (count up by one),
//        i_clr (zero; combined with i_inc the result is 1),
//        i_load/i_load_val (load wins over clear and increment),
//        o_cnt (current value, sticks at all-ones).
module apb_mon_sat_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_clr) begin
            r_cnt <= i_inc ? W'(1) : '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB protocol monitor.
// Tracks IDLE/SETUP/ACCESS per sample, raises sticky error bits with an
// enable-masked interrupt, captures the first error (code + address),
// counts completed reads/writes and records the worst wait-state count.
// Inputs: PCLK, PRESETn, tapped bus signals (PSELx_i, PENABLE_i, PWRITE_i,
//         PADDR_i, PWDATA_i, PREADY_o, PRDATA_o), err_en_i, err_clr_i,
//         cnt_clr_i.
// Outputs: err_sts_o, err_irq_o, first_err_code_o, first_err_addr_o,
//          wr_cnt_o, rd_cnt_o, max_wait_o, phase_o.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned NUM_WR_ADDR = 4,
    parameter logic [NUM_WR_ADDR*ADDR_W-1:0] WR_ADDR_LIST = {8'h04, 8'h02, 8'h01, 8'h00},
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx_i,
    input  logic              PENABLE_i,
    input  logic              PWRITE_i,
    input  logic [ADDR_W-1:0] PADDR_i,
    input  logic [DATA_W-1:0] PWDATA_i,
    input  logic              PREADY_o,
    input  logic [DATA_W-1:0] PRDATA_o,
    input  logic [5:0]        err_en_i,
    input  logic              err_clr_i,
    input  logic              cnt_clr_i,
    output logic [5:0]        err_sts_o,
    output logic              err_irq_o,
    output logic [2:0]        first_err_code_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [7:0]        max_wait_o,
    output logic [1:0]        phase_o
);

    phase_e              r_phase;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [7:0]          r_wait;
    logic                r_to_done;
    logic [NUM_ERR-1:0]  r_err_sts;
    logic                r_irq;
    logic [2:0]          r_first_code;
    logic [ADDR_W-1:0]   r_first_addr;

    phase_e              w_nxt_phase;
    logic [NUM_ERR-1:0]  w_err;
    logic [NUM_ERR-1:0]  w_sts_base;
    logic                w_done;
    logic [7:0]          w_done_wait;
    logic                w_latch;
    logic [7:0]          w_wait_nxt;
    logic [7:0]          w_wait_inc;
    logic                w_to_nxt;
    logic [ADDR_W-1:0]   w_cap_addr;
    logic                w_addr_legal;
    logic                w_unstable;
    logic                w_unused_rdata;

    // Read data is observed only.
    assign w_unused_rdata = ^PRDATA_o;

    always_comb begin
        w_addr_legal = 1'b0;
        for (int unsigned i = 0; i < NUM_WR_ADDR; i++) begin
            if (PADDR_i == WR_ADDR_LIST[i*ADDR_W +: ADDR_W]) w_addr_legal = 1'b1;
        end
    end

    assign w_unstable = (PADDR_i != r_addr) || (PWRITE_i != r_write) ||
                        (r_write && (PWDATA_i != r_wdata));
    assign w_wait_inc = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;

    always_comb begin
        w_err       = '0;
        w_done      = 1'b0;
        w_done_wait = '0;
        w_nxt_phase = r_phase;
        w_latch     = 1'b0;
        w_wait_nxt  = r_wait;
        w_to_nxt    = r_to_done;
        w_cap_addr  = r_addr;
        unique case (r_phase)
            IDLE: begin
                if (PENABLE_i) begin
                    w_err[ERR_NO_SETUP] = 1'b1;
                    w_cap_addr          = PADDR_i;
                end else if (PSELx_i) begin
                    w_latch     = 1'b1;
                    w_nxt_phase = SETUP;
                    w_cap_addr  = PADDR_i;
                end
            end
            SETUP: begin
                if (PSELx_i && PENABLE_i) begin
                    w_err[ERR_UNSTABLE] = w_unstable;
                    if (PREADY_o) begin
                        w_done      = 1'b1;
                        w_nxt_phase = IDLE;
                    end else begin
                        w_nxt_phase          = ACCESS;
                        w_wait_nxt           = 8'd1;
                        w_to_nxt             = (TIMEOUT_CYC == 1);
                        w_err[ERR_TIMEOUT]   = (TIMEOUT_CYC == 1);
                    end
                end else begin
                    // A repeated setup relatches; the error reports the old address.
                    w_err[ERR_NO_ACCESS] = 1'b1;
                    if (PSELx_i) w_latch = 1'b1;
                    else         w_nxt_phase = IDLE;
                end
            end
            ACCESS: begin
                if (PSELx_i && PENABLE_i) begin
                    w_err[ERR_UNSTABLE] = w_unstable;
                    if (PREADY_o) begin
                        w_done      = 1'b1;
                        w_done_wait = r_wait;
                        w_nxt_phase = IDLE;
                    end else begin
                        w_wait_nxt = w_wait_inc;
                        if ((w_wait_inc == 8'(TIMEOUT_CYC)) && !r_to_done) begin
                            w_err[ERR_TIMEOUT] = 1'b1;
                            w_to_nxt           = 1'b1;
                        end
                    end
                end else begin
                    w_err[ERR_ABORT] = 1'b1;
                    w_nxt_phase      = IDLE;
                end
            end
            default: w_nxt_phase = IDLE;
        endcase
        if (w_latch && PWRITE_i && !w_addr_legal) w_err[ERR_WR_ADDR] = 1'b1;
    end

    // Clear is applied before this cycle's new errors are merged in.
    assign w_sts_base = err_clr_i ? '0 : r_err_sts;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_phase      <= IDLE;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_wait       <= '0;
            r_to_done    <= 1'b0;
            r_err_sts    <= '0;
            r_irq        <= 1'b0;
            r_first_code <= '0;
            r_first_addr <= '0;
        end else begin
            r_phase   <= w_nxt_phase;
            r_wait    <= w_wait_nxt;
            r_to_done <= w_to_nxt;
            if (w_latch) begin
                r_addr  <= PADDR_i;
                r_write <= PWRITE_i;
                r_wdata <= PWDATA_i;
            end
            r_err_sts <= w_sts_base | w_err;
            if ((w_err != '0) && (w_sts_base == '0)) begin
                r_first_code <= lowest_err(w_err);
                r_first_addr <= w_cap_addr;
            end else if (err_clr_i) begin
                r_first_code <= '0;
                r_first_addr <= '0;
            end
            r_irq <= |(r_err_sts & err_en_i);
        end
    end

    apb_mon_sat_cnt #(.W(CNT_W)) u_wr_cnt (
        .i_clk      (PCLK),
        .i_rst_n    (PRESETn),
        .i_inc      (w_done && r_write),
        .i_clr      (cnt_clr_i),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (wr_cnt_o)
    );

    apb_mon_sat_cnt #(.W(CNT_W)) u_rd_cnt (
        .i_clk      (PCLK),
        .i_rst_n    (PRESETn),
        .i_inc      (w_done && !r_write),
        .i_clr      (cnt_clr_i),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_cnt      (rd_cnt_o)
    );

    apb_mon_sat_cnt #(.W(8)) u_max_wait (
        .i_clk      (PCLK),
        .i_rst_n    (PRESETn),
        .i_inc      (1'b0),
        .i_clr      (cnt_clr_i),
        .i_load     (w_done && (cnt_clr_i || (w_done_wait > max_wait_o))),
        .i_load_val (w_done_wait),
        .o_cnt      (max_wait_o)
    );

    assign err_sts_o        = r_err_sts;
    assign err_irq_o        = r_irq;
    assign first_err_code_o = r_first_code;
    assign first_err_addr_o = r_first_addr;
    assign phase_o          = r_phase;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Self-checking bench for apb_protocol_monitor: directed bus scenarios,
// a cycle model built from the bus rules, a per-cycle compare process,
// and literal checks at the end of each scenario.
module tb_apb_protocol_monitor;

    localparam int TIMEOUT = 16;

    logic        PCLK, PRESETn;
    logic        PSELx, PENABLE, PWRITE, PREADY;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic [5:0]  err_en;
    logic        err_clr, cnt_clr;
    logic [5:0]  err_sts_o;
    logic        err_irq_o;
    logic [2:0]  first_err_code_o;
    logic [7:0]  first_err_addr_o;
    logic [15:0] wr_cnt_o, rd_cnt_o;
    logic [7:0]  max_wait_o;
    logic [1:0]  phase_o;

    apb_protocol_monitor #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .PCLK             (PCLK),
        .PRESETn          (PRESETn),
        .PSELx_i          (PSELx),
        .PENABLE_i        (PENABLE),
        .PWRITE_i         (PWRITE),
        .PADDR_i          (PADDR),
        .PWDATA_i         (PWDATA),
        .PREADY_o         (PREADY),
        .PRDATA_o         (PRDATA),
        .err_en_i         (err_en),
        .err_clr_i        (err_clr),
        .cnt_clr_i        (cnt_clr),
        .err_sts_o        (err_sts_o),
        .err_irq_o        (err_irq_o),
        .first_err_code_o (first_err_code_o),
        .first_err_addr_o (first_err_addr_o),
        .wr_cnt_o         (wr_cnt_o),
        .rd_cnt_o         (rd_cnt_o),
        .max_wait_o       (max_wait_o),
        .phase_o          (phase_o)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] legal_list [4] = '{8'h00, 8'h01, 8'h02, 8'h04};

    int         m_ph = 0;       // 0 idle, 1 setup, 2 access
    logic [7:0] m_addr = 0;
    bit         m_wr = 0;
    logic [31:0] m_wdata = 0;
    int         m_wait = 0;
    bit         m_to = 0;
    logic [5:0] m_sts = 0;
    int         m_code = 0;
    logic [7:0] m_faddr = 0;
    int         m_wrc = 0, m_rdc = 0, m_max = 0;
    bit         m_irq = 0;

    function automatic bit is_legal(input logic [7:0] a);
        for (int i = 0; i < 4; i++) if (legal_list[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit bus_changed();
        return (PADDR !== m_addr) || (PWRITE !== m_wr) || (m_wr && (PWDATA !== m_wdata));
    endfunction

    always @(posedge PCLK or negedge PRESETn) begin
        bit [5:0]   e;
        bit         done;
        int         dw;
        logic [7:0] caddr;
        bit         take;
        if (!PRESETn) begin
            m_ph = 0; m_addr = 0; m_wr = 0; m_wdata = 0; m_wait = 0; m_to = 0;
            m_sts = 0; m_code = 0; m_faddr = 0; m_wrc = 0; m_rdc = 0; m_max = 0; m_irq = 0;
        end else begin
            e = 0; done = 0; dw = 0; caddr = m_addr; take = 0;
            m_irq = (m_sts & err_en) != 0;
            if (m_ph == 0) begin
                if (PENABLE) begin e[0] = 1; caddr = PADDR; end
                else if (PSELx) begin take = 1; caddr = PADDR; m_ph = 1; end
            end else if (m_ph == 1) begin
                if (PSELx && PENABLE) begin
                    if (bus_changed()) e[2] = 1;
                    if (PREADY) begin done = 1; dw = 0; m_ph = 0; end
                    else begin
                        m_wait = 1; m_ph = 2; m_to = 0;
                        if (TIMEOUT == 1) begin e[3] = 1; m_to = 1; end
                    end
                end else begin
                    e[1] = 1;
                    if (PSELx) take = 1; else m_ph = 0;
                end
            end else begin
                if (PSELx && PENABLE) begin
                    if (bus_changed()) e[2] = 1;
                    if (PREADY) begin done = 1; dw = m_wait; m_ph = 0; end
                    else begin
                        if (m_wait < 255) m_wait++;
                        if (m_wait == TIMEOUT && !m_to) begin e[3] = 1; m_to = 1; end
                    end
                end else begin
                    e[5] = 1; m_ph = 0;
                end
            end
            if (take) begin
                if (PWRITE && !is_legal(PADDR)) e[4] = 1;
                m_addr = PADDR; m_wr = PWRITE; m_wdata = PWDATA;
            end
            if (err_clr) m_sts = 0;
            if (e != 0 && m_sts == 0) begin
                for (int i = 5; i >= 0; i--) if (e[i]) m_code = i;
                m_faddr = caddr;
            end else if (err_clr) begin
                m_code = 0; m_faddr = 0;
            end
            m_sts = m_sts | e;
            if (cnt_clr) begin m_wrc = 0; m_rdc = 0; m_max = 0; end
            if (done) begin
                if (m_wr) begin if (m_wrc < 65535) m_wrc++; end
                else      begin if (m_rdc < 65535) m_rdc++; end
                if (dw > m_max) m_max = dw;
            end
        end
    end

    always @(negedge PCLK) begin
        if (cmp_on) begin
            chk("cyc_sts",   err_sts_o,        m_sts);
            chk("cyc_irq",   err_irq_o,        m_irq);
            chk("cyc_code",  first_err_code_o, m_code);
            chk("cyc_faddr", first_err_addr_o, m_faddr);
            chk("cyc_wrcnt", wr_cnt_o,         m_wrc);
            chk("cyc_rdcnt", rd_cnt_o,         m_rdc);
            chk("cyc_max",   max_wait_o,       m_max);
            chk("cyc_phase", phase_o,          m_ph);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit sel, input bit en, input bit wr, input logic [7:0] a,
                         input logic [31:0] d, input bit rdy);
        PSELx = sel; PENABLE = en; PWRITE = wr; PADDR = a; PWDATA = d; PREADY = rdy;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 8'h00, 32'h0, 0);
        repeat (n) @(negedge PCLK);
    endtask

    // Leaves the bus idle but does not spend a cycle, so calls can run back to back.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input int waits, input bit clr_end);
        drive(1, 0, wr, a, d, 0);
        @(negedge PCLK);
        for (int i = 0; i < waits; i++) begin
            drive(1, 1, wr, a, d, 0);
            @(negedge PCLK);
        end
        drive(1, 1, wr, a, d, 1);
        cnt_clr = clr_end;
        @(negedge PCLK);
        cnt_clr = 1'b0;
        drive(0, 0, 0, 8'h00, 32'h0, 0);
    endtask

    task automatic pulse_err_clr();
        drive(0, 0, 0, 8'h00, 32'h0, 0);
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
    endtask

    initial begin
        PRESETn = 1'b0;
        err_en = '0; err_clr = 1'b0; cnt_clr = 1'b0; PRDATA = 32'hDEAD_BEEF;
        drive(0, 0, 0, 8'h00, 32'h0, 0);
        repeat (2) @(negedge PCLK);
        cmp_on = 1'b1;
        chk("rst_sts",   err_sts_o, 0);
        chk("rst_wrcnt", wr_cnt_o,  0);
        chk("rst_phase", phase_o,   0);
        PRESETn = 1'b1;
        idle(2);

        // Write to 0x02, zero waits
        xfer(1, 8'h02, 32'h1234_5678, 0, 0);
        chk("w02_phase", phase_o,    0);
        chk("w02_wrcnt", wr_cnt_o,   1);
        chk("w02_max",   max_wait_o, 0);
        chk("w02_sts",   err_sts_o,  0);

        // Read 0x10 with 3 waits, then back-to-back read with 1 wait
        xfer(0, 8'h10, 32'h0, 3, 0);
        chk("r3_rdcnt", rd_cnt_o,   1);
        chk("r3_max",   max_wait_o, 3);
        xfer(0, 8'h10, 32'h0, 1, 0);
        chk("r1_rdcnt", rd_cnt_o,   2);
        chk("r1_max",   max_wait_o, 3);
        idle(1);

        // Illegal write address 0x03 with E4 enabled
        err_en = 6'h10;
        drive(1, 0, 1, 8'h03, 32'hA5A5_A5A5, 0);
        @(negedge PCLK);
        chk("e4_sts",   err_sts_o,        6'h10);
        chk("e4_code",  first_err_code_o, 4);
        chk("e4_addr",  first_err_addr_o, 8'h03);
        chk("e4_irq0",  err_irq_o,        0);
        drive(1, 1, 1, 8'h03, 32'hA5A5_A5A5, 1);
        @(negedge PCLK);
        chk("e4_irq1",  err_irq_o,        1);
        chk("e4_wrcnt", wr_cnt_o,         2);
        idle(1);
        pulse_err_clr();
        chk("e4_clr", err_sts_o, 0);
        err_en = 6'h3F;
        idle(2);

        // Address change during wait, then timeout
        drive(1, 0, 1, 8'h01, 32'h0000_00C3, 0);
        @(negedge PCLK);
        drive(1, 1, 1, 8'h01, 32'h0000_00C3, 0);
        @(negedge PCLK);
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, 1, 8'h02, 32'h0000_00C3, 0);
            @(negedge PCLK);
        end
        drive(1, 1, 1, 8'h02, 32'h0000_00C3, 1);
        @(negedge PCLK);
        idle(1);
        chk("to_sts",   err_sts_o,        6'h0C);
        chk("to_code",  first_err_code_o, 2);
        chk("to_addr",  first_err_addr_o, 8'h01);
        chk("to_max",   max_wait_o,       21);
        chk("to_wrcnt", wr_cnt_o,         3);
        pulse_err_clr();
        idle(2);

        // Enable without setup, then clear coincident with a new E1
        drive(0, 1, 0, 8'h33, 32'h0, 0);
        @(negedge PCLK);
        chk("e0_sts",  err_sts_o,        6'h01);
        chk("e0_code", first_err_code_o, 0);
        chk("e0_addr", first_err_addr_o, 8'h33);
        drive(1, 0, 0, 8'h20, 32'h0, 0);
        @(negedge PCLK);
        drive(0, 0, 0, 8'h00, 32'h0, 0);
        err_clr = 1'b1;
        @(negedge PCLK);
        err_clr = 1'b0;
        chk("e1_sts",   err_sts_o,        6'h02);
        chk("e1_code",  first_err_code_o, 1);
        chk("e1_addr",  first_err_addr_o, 8'h20);
        chk("e1_phase", phase_o,          0);
        pulse_err_clr();
        idle(1);

        // Counter clear coincident with a completion; legal edge address 0x04
        xfer(0, 8'h10, 32'h0, 2, 1);
        chk("cc_rdcnt", rd_cnt_o,   1);
        chk("cc_wrcnt", wr_cnt_o,   0);
        chk("cc_max",   max_wait_o, 2);
        xfer(1, 8'h04, 32'h4444_0000, 0, 0);
        chk("w04_sts",   err_sts_o, 0);
        chk("w04_wrcnt", wr_cnt_o,  1);
        idle(2);

        // Reset during the access of a long-wait write
        drive(1, 0, 1, 8'h02, 32'h5555_0000, 0);
        @(negedge PCLK);
        drive(1, 1, 1, 8'h02, 32'h5555_0000, 0);
        repeat (2) @(negedge PCLK);
        #3 PRESETn = 1'b0;
        #1;
        chk("ar_sts",   err_sts_o,        0);
        chk("ar_irq",   err_irq_o,        0);
        chk("ar_code",  first_err_code_o, 0);
        chk("ar_wrcnt", wr_cnt_o,         0);
        chk("ar_rdcnt", rd_cnt_o,         0);
        chk("ar_max",   max_wait_o,       0);
        chk("ar_phase", phase_o,          0);
        drive(0, 0, 0, 8'h00, 32'h0, 0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        idle(3);
        chk("rel_wrcnt", wr_cnt_o,  0);
        chk("rel_sts",   err_sts_o, 0);
        chk("rel_phase", phase_o,   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
